// File: rtl/rmc_engine.sv
// Remote memory controller engine: executes READ/WRITE requests from a show-ahead
// request FIFO against a local data memory, pushing read results into a read FIFO.

module rmc_data_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  parameter int AW         = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Not reset: contents survive an engine reset, and rdata holds until the next read.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

module rmc_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  halt,
  input  logic [DATA_WIDTH-1:0] req_fifo_data,
  output logic                  req_fifo_deq,
  input  logic                  req_fifo_rdempty,
  output logic [DATA_WIDTH-1:0] read_fifo_data_in,
  output logic                  read_fifo_enq,
  input  logic                  read_fifo_wrfull
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = DATA_WIDTH - 1;
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [AW-1:0] ADDR_ONE = 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WR,
    RD_ISSUE,
    RD_PUSH
  } state_t;

  state_t                state, state_next;
  logic                  is_write, is_write_next;
  logic [CW-1:0]         count, count_next;
  logic [AW-1:0]         addr, addr_next;
  logic                  mem_we, mem_re;
  logic [DATA_WIDTH-1:0] mem_rdata;

  rmc_data_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (AW)
  ) data_mem (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (addr),
    .wdata(req_fifo_data),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      is_write <= 1'b0;
      count    <= '0;
      addr     <= '0;
    end else begin
      state    <= state_next;
      is_write <= is_write_next;
      count    <= count_next;
      addr     <= addr_next;
    end
  end

  // Strobes are combinational so each FIFO transfer lands on the same edge the state advances.
  always_comb begin
    state_next    = state;
    is_write_next = is_write;
    count_next    = count;
    addr_next     = addr;
    req_fifo_deq  = 1'b0;
    read_fifo_enq = 1'b0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    case (state)
      IDLE: begin
        if (!req_fifo_rdempty) begin
          req_fifo_deq  = 1'b1;
          is_write_next = req_fifo_data[0];
          count_next    = req_fifo_data[DATA_WIDTH-1:1];
          state_next    = ADDR;
        end
      end
      ADDR: begin
        if (!req_fifo_rdempty) begin
          req_fifo_deq = 1'b1;
          addr_next    = req_fifo_data[AW-1:0];
          if (count == '0)   state_next = IDLE;
          else if (is_write) state_next = WR;
          else               state_next = RD_ISSUE;
        end
      end
      WR: begin
        if (!req_fifo_rdempty) begin
          req_fifo_deq = 1'b1;
          mem_we       = 1'b1;
          addr_next    = addr + ADDR_ONE;
          count_next   = count - CNT_ONE;
          if (count == CNT_ONE) state_next = IDLE;
        end
      end
      RD_ISSUE: begin
        mem_re     = 1'b1;
        state_next = RD_PUSH;
      end
      RD_PUSH: begin
        if (!read_fifo_wrfull) begin
          read_fifo_enq = 1'b1;
          addr_next     = addr + ADDR_ONE;
          count_next    = count - CNT_ONE;
          state_next    = (count == CNT_ONE) ? IDLE : RD_ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Gate the memory output so the push data is zero outside RD_PUSH, including after reset.
  assign read_fifo_data_in = (state == RD_PUSH) ? mem_rdata : '0;
  assign halt              = (state == IDLE) && req_fifo_rdempty;

endmodule

// File: tb/tb_rmc_engine.sv
// Randomized scoreboard bench for rmc_engine: behavioural FIFO models on both sides,
// a reference memory image, and a monitor that checks every pushed read word.

module tb_rmc_engine;

  localparam int DW    = 32;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          halt;
  logic [DW-1:0] req_fifo_data = '0;
  logic          req_fifo_deq;
  logic          req_fifo_rdempty = 1'b1;
  logic [DW-1:0] read_fifo_data_in;
  logic          read_fifo_enq;
  logic          read_fifo_wrfull = 1'b0;

  rmc_engine #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .halt             (halt),
    .req_fifo_data    (req_fifo_data),
    .req_fifo_deq     (req_fifo_deq),
    .req_fifo_rdempty (req_fifo_rdempty),
    .read_fifo_data_in(read_fifo_data_in),
    .read_fifo_enq    (read_fifo_enq),
    .read_fifo_wrfull (read_fifo_wrfull)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int enq_count  = 0;

  logic [DW-1:0] pend_q[$];
  logic [DW-1:0] req_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] wr_data[$];
  logic [DW-1:0] ref_mem [DEPTH];

  int host_pct = 100;
  int cons_pct = 100;
  int rd_depth = 4;

  logic          cap_deq  = 1'b0;
  logic          cap_enq  = 1'b0;
  logic [DW-1:0] cap_data = '0;

  task automatic checkOutput(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Queue one request; the reference memory is updated in issue order, which matches execution order.
  task automatic applyStimulus(input bit wr, input int n, input logic [DW-1:0] addr);
    logic [DW-1:0] d;
    int a;
    pend_q.push_back((DW'(n) << 1) | DW'(wr));
    pend_q.push_back(addr);
    for (int k = 0; k < n; k++) begin
      a = int'((addr + DW'(k)) % DEPTH);
      if (wr) begin
        d = (k < wr_data.size()) ? wr_data[k] : DW'($urandom);
        ref_mem[a] = d;
        pend_q.push_back(d);
      end else begin
        exp_q.push_back(ref_mem[a]);
      end
    end
    wr_data.delete();
  endtask

  task automatic waitIdle(input string name);
    bit done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      #3;
      if (pend_q.size() == 0 && req_q.size() == 0 && exp_q.size() == 0 && halt) done = 1;
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("[TB] FAIL %s_timeout: got busy expected idle (pend=%0d exp=%0d)", name, pend_q.size(), exp_q.size());
    end
  endtask

  task automatic checkMem(input string name);
    for (int i = 0; i < DEPTH; i++) checkOutput(name, dut.data_mem.mem[i], ref_mem[i]);
  endtask

  // FIFO models: retire the transfers of the edge just passed, feed/drain, then capture the strobes for the next edge.
  always @(negedge clk) begin
    if (cap_deq) void'(req_q.pop_front());
    if (cap_enq) rd_q.push_back(cap_data);
    if (pend_q.size() > 0 && req_q.size() < 16 && $urandom_range(99) < host_pct)
      req_q.push_back(pend_q.pop_front());
    if (rd_q.size() > 0 && $urandom_range(99) < cons_pct) void'(rd_q.pop_front());
    req_fifo_rdempty = (req_q.size() == 0);
    req_fifo_data    = req_fifo_rdempty ? '0 : req_q[0];
    read_fifo_wrfull = (rd_q.size() >= rd_depth);
    #1;
    if (req_fifo_deq) checkOutput("deq_when_empty", DW'(req_fifo_rdempty), '0);
    if (read_fifo_enq) checkOutput("enq_when_full", DW'(read_fifo_wrfull), '0);
    cap_deq  = rstn && req_fifo_deq;
    cap_enq  = rstn && read_fifo_enq;
    cap_data = read_fifo_data_in;
  end

  // Monitor: every push to the read FIFO is matched against the next expected word.
  always @(posedge clk) begin
    if (cap_enq) begin
      enq_count++;
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_enq: got %h expected no push", cap_data);
      end else begin
        checkOutput("read_data", cap_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int e0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = DW'($urandom);
      dut.data_mem.mem[i] = ref_mem[i];
    end
    repeat (3) @(negedge clk);
    #2;
    checkOutput("reset_deq", DW'(req_fifo_deq), '0);
    checkOutput("reset_enq", DW'(read_fifo_enq), '0);
    checkOutput("reset_data", read_fifo_data_in, '0);
    checkOutput("reset_halt", DW'(halt), DW'(1));
    rstn = 1'b1;

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #2;
      checkOutput("idle_halt", DW'(halt), DW'(1));
      checkOutput("idle_strobes", DW'({req_fifo_deq, read_fifo_enq}), '0);
    end

    wr_data = '{32'hA, 32'hB, 32'hC};
    applyStimulus(1, 3, 5);
    waitIdle("write3");
    checkOutput("mem5", dut.data_mem.mem[5], 32'hA);
    checkOutput("mem6", dut.data_mem.mem[6], 32'hB);
    checkOutput("mem7", dut.data_mem.mem[7], 32'hC);
    checkOutput("halt_after_write", DW'(halt), DW'(1));

    ref_mem[10] = 32'h11;
    ref_mem[11] = 32'h22;
    dut.data_mem.mem[10] = 32'h11;
    dut.data_mem.mem[11] = 32'h22;
    e0 = enq_count;
    applyStimulus(0, 2, 10);
    waitIdle("read2");
    checkOutput("read2_enq_count", DW'(enq_count - e0), DW'(2));

    wr_data = '{32'h55};
    applyStimulus(1, 1, 3);
    applyStimulus(0, 1, 3);
    waitIdle("write_then_read");

    cons_pct = 50;
    e0 = enq_count;
    applyStimulus(0, 8, DW'(DEPTH - 2));
    waitIdle("read_wrap");
    checkOutput("wrap_enq_count", DW'(enq_count - e0), DW'(8));

    host_pct = 25;
    for (int r = 0; r < 5; r++)
      applyStimulus(1'($urandom_range(1)), $urandom_range(1, 8), DW'($urandom));
    waitIdle("random");
    checkMem("mem_image");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rmc_engine.md
# rmc_engine

Remote memory controller engine. It consumes a word stream of read/write requests from a show-ahead request FIFO and executes each request against its local data memory. Read results are pushed into a read-data FIFO. It sits between the host-side request FIFO and the return-path FIFO, both built from `fifo_ack` instances (acknowledge-style, show-ahead).

## Interface
- `DATA_WIDTH`, default 32: word width of FIFOs and memory.
- `MEM_DEPTH`, default 256 (power of 2): data memory words. `AW = log2(MEM_DEPTH)`.
- `clk`  in  1  clock; all state changes on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `halt`  out  1  high when the engine is in IDLE and `req_fifo_rdempty`=1.
- `req_fifo_data`  in  DATA_WIDTH  head word of the request FIFO, valid when `req_fifo_rdempty`=0.
- `req_fifo_deq`  out  1  acknowledge/pop of the head word.
- `req_fifo_rdempty`  in  1  request FIFO empty.
- `read_fifo_data_in`  out  DATA_WIDTH  word pushed to the read FIFO.
- `read_fifo_enq`  out  1  push strobe.
- `read_fifo_wrfull`  in  1  read FIFO full.
- The data memory is an instance named `data_mem` holding array `mem[MEM_DEPTH]` of DATA_WIDTH. It is not reset, and benches preload it hierarchically.

## Operation
- Request format, in order:
  - Word 0 (header): `[0]` = type (0 = READ, 1 = WRITE); `[DATA_WIDTH-1:1]` = `num_words` (unsigned).
  - Word 1: start address.
  - WRITE: followed by `num_words` data words. READ: no further words.
- Word k of a request targets `mem[(addr + k) mod MEM_DEPTH]`. Only the low `AW` address bits are used, so addresses wrap around.
- States:
  - IDLE: `req_fifo_rdempty`=0 → deq the header, latch type and count → ADDR.
  - ADDR: on a non-empty head, deq and latch `addr[AW-1:0]`.
    - `num_words`=0 → IDLE.
    - Otherwise WRITE → WR; READ → RD_ISSUE.
  - WR: on a non-empty head:
    - `mem[addr]` ← head; deq; addr+1; count−1.
    - count reaches 0 → IDLE.
  - RD_ISSUE: synchronous memory read of `mem[addr]` → RD_PUSH.
  - RD_PUSH: hold data on `read_fifo_data_in`. When `read_fifo_wrfull`=0, assert `read_fifo_enq`, then addr+1 and count−1. Next state is IDLE if count reached 0, else RD_ISSUE.
- `req_fifo_deq` is asserted only in IDLE, ADDR or WR, and only when `req_fifo_rdempty`=0. It is never asserted while empty.
- `read_fifo_enq` is asserted only when `read_fifo_wrfull`=0.
- Requests execute strictly in order. Read data is pushed in address order.
- Count arithmetic is DATA_WIDTH−1 bits wide, unsigned.
- `fifo_ack` FIFO contract (used on both sides):
  - `data_out` shows the head when not empty.
  - `deq` pops on a clock edge and is ignored when empty.
  - `enq` writes on a clock edge and is ignored when full.
  - A simultaneous enq and deq both take effect.
  - Reset empties the FIFO; `DEPTH` is a power of 2.

## Timing
- Reset (async): state IDLE, `req_fifo_deq`=0, `read_fifo_enq`=0, `read_fifo_data_in`=0, counters 0. `halt` follows its definition.
- Reset mid-request aborts it:
  - Memory writes already done remain.
  - No further deq or enq.
  - Unconsumed FIFO words are handled by the FIFOs' own reset.
- `req_fifo_deq` and `read_fifo_enq` are combinational from state and flags. The transfer occurs at the same rising edge.
- Stall behaviour: empty request FIFO, or a full read FIFO in RD_PUSH, holds all state indefinitely with no loss or duplication.
- Memory write takes effect at the edge where the word is dequeued. A later read of the same address returns the new value.
- Best-case rates:
  - Header + address: 2 cycles.
  - WRITE: 1 word/cycle.
  - READ: 1 word per 2 cycles (RD_ISSUE + RD_PUSH).
- A new request's header may be dequeued in the first IDLE cycle after completion.

## Test plan
- Reset, then FIFO empty → `halt`=1, no deq/enq strobes for 20 cycles.
- WRITE `num_words`=3 at addr 5 (header 0x7, addr 5, data 0xA, 0xB, 0xC) → `mem[5..7]` = A, B, C; `halt`=1 afterwards.
- Preload `mem[10..11]` = 0x11, 0x22; READ 2 at addr 10 (header 0x4) → read FIFO receives 0x11 then 0x22; exactly 2 enqs.
- WRITE 1 to addr 3 with 0x55, then READ 1 from addr 3 → read FIFO receives 0x55.
- READ 8 at addr `MEM_DEPTH`−2 with a depth-4 read FIFO dequeued randomly at 50% → 8 words, addresses wrap to 0..5, no loss; deq/enq only when not empty/full.
- 5 random requests (1–8 words) fed with 25% enq probability → memory image and read stream match a reference model exactly.
